// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the SAR conversion sequencer.
//   state_e        - sequencer FSM states
//   RES_MAX        - widest supported conversion (bits)
//   SAMP_CYC_DEF   - default sampling-phase length (cycles)
//   NBITS_W        - width of the runtime resolution field
//   resolve_nbits  - maps a requested resolution onto the legal 1..res range
package adc_pkg;

  localparam int RES_MAX      = 16;
  localparam int SAMP_CYC_DEF = 4;
  localparam int NBITS_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SAMP,
    ST_COMP,
    ST_UPDATE
  } state_e;

  // A request of 0, or one wider than the converter, means full resolution.
  function automatic logic [NBITS_W-1:0] resolve_nbits(input logic [NBITS_W-1:0] nbits,
                                                       input int res);
    if (nbits == '0 || int'(nbits) > res) return NBITS_W'(res);
    return nbits;
  endfunction

endpackage

// File: rtl/adc_outbuf.sv
// adc_outbuf: result holding register with valid/ready handshake and a sticky
// overrun flag.
//   clk, rst      - clock, asynchronous active-high reset
//   load          - pulse: new conversion result available on load_data
//   load_data     - result to capture
//   code_ready    - consumer accepts the held result
//   clr_ovr       - clears the overrun flag
//   code_data     - held result (stable while code_valid=1)
//   code_valid    - result held and not yet consumed
//   overrun       - sticky: a result was overwritten before being consumed
module adc_outbuf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         code_ready,
  input  logic         clr_ovr,
  output logic [W-1:0] code_data,
  output logic         code_valid,
  output logic         overrun
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  logic         ovr_set;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      // Losing a result only counts when the consumer did not take it this edge.
      ovr_set = valid_q & ~code_ready;
    end else if (valid_q && code_ready) begin
      valid_d = 1'b0;
    end
    // A set wins over a simultaneous clear.
    ovr_d = ovr_set | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign code_data  = data_q;
  assign code_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/sar_sequencer.sv
// sar_sequencer: successive-approximation conversion sequencer. Generates the
// INIT/SAMP/COMP/UPDATE phase strobes, collects comparator decisions MSB first
// and hands finished results to adc_outbuf.
//   clk, rst                  - clock, asynchronous active-high reset
//   start, cont, abort        - single conversion, continuous mode, abort
//   nbits                     - runtime resolution (0 or >RES means RES)
//   comp_out                  - comparator decision, sampled at end of UPDATE
//   seq_init/samp/comp/update - one-hot phase strobes (registered)
//   busy                      - any state other than IDLE
//   code_data/valid/ready     - result handshake
//   overrun, clr_ovr          - sticky lost-result flag and its clear
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start or cont; latches resolution on exit
// ST_INIT   | one cycle: clear shift register, arm sample counter/index
// ST_SAMP   | SAMP_CYC cycles, counted down to zero
// ST_COMP   | comparator settles for the current bit
// ST_UPDATE | comp_out written into bit [idx]; last bit loads the result
module sar_sequencer
  import adc_pkg::*;
#(
  parameter int RES      = RES_MAX,
  parameter int SAMP_CYC = SAMP_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic               abort,
  input  logic [NBITS_W-1:0] nbits,
  input  logic               comp_out,
  output logic               seq_init,
  output logic               seq_samp,
  output logic               seq_comp,
  output logic               seq_update,
  output logic               busy,
  output logic [RES-1:0]     code_data,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               overrun,
  input  logic               clr_ovr
);

  localparam int               IDX_W         = (RES > 1) ? $clog2(RES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP       = IDX_W'(RES - 1);
  localparam logic [7:0]       SAMP_CNT_INIT = 8'(SAMP_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       samp_cnt_q, samp_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] lsb_q, lsb_d;
  logic [RES-1:0]   sreg_q, sreg_d;
  logic             seq_init_q, seq_samp_q, seq_comp_q, seq_update_q, busy_q;
  logic             load;

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    idx_d      = idx_q;
    lsb_d      = lsb_q;
    sreg_d     = sreg_q;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d = ST_INIT;
          // Only the lowest bit index is kept; bits below it are never written.
          lsb_d   = IDX_W'(RES - int'(resolve_nbits(nbits, RES)));
        end
      end
      ST_INIT: begin
        state_d    = ST_SAMP;
        samp_cnt_d = SAMP_CNT_INIT;
        idx_d      = IDX_TOP;
        sreg_d     = '0;
      end
      ST_SAMP: begin
        if (samp_cnt_q == '0) state_d = ST_COMP;
        else                  samp_cnt_d = samp_cnt_q - 8'd1;
      end
      ST_COMP: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        sreg_d[idx_q] = comp_out;
        if (idx_q == lsb_q) begin
          load    = 1'b1;
          state_d = cont ? ST_INIT : ST_IDLE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_COMP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      sreg_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      samp_cnt_q   <= '0;
      idx_q        <= '0;
      lsb_q        <= '0;
      sreg_q       <= '0;
      seq_init_q   <= 1'b0;
      seq_samp_q   <= 1'b0;
      seq_comp_q   <= 1'b0;
      seq_update_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      idx_q        <= idx_d;
      lsb_q        <= lsb_d;
      sreg_q       <= sreg_d;
      // Strobes are registered from the next state so they align with state_q.
      seq_init_q   <= (state_d == ST_INIT);
      seq_samp_q   <= (state_d == ST_SAMP);
      seq_comp_q   <= (state_d == ST_COMP);
      seq_update_q <= (state_d == ST_UPDATE);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign seq_init   = seq_init_q;
  assign seq_samp   = seq_samp_q;
  assign seq_comp   = seq_comp_q;
  assign seq_update = seq_update_q;
  assign busy       = busy_q;

  adc_outbuf #(.W(RES)) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (sreg_d),
    .code_ready (code_ready),
    .clr_ovr    (clr_ovr),
    .code_data  (code_data),
    .code_valid (code_valid),
    .overrun    (overrun)
  );

endmodule
